// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 4-stage pipeline: load-use and MUL stalls, branch flushes, forwarding.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int unsigned RAW        = 3,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RAW-1:0]   id_rs1,
  input  logic [RAW-1:0]   id_rs2,
  input  logic             id_uses_rs2,
  input  logic             id_is_mul,
  input  logic             ex_valid,
  input  logic [RAW-1:0]   ex_rd,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             wb_valid,
  input  logic [RAW-1:0]   wb_rd,
  input  logic             wb_we,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned CW = $clog2(MUL_CYCLES);
  // Entry cycle stalls in RUN, then MUL_CYCLES-1 busy cycles stall before the cnt==0 release.
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {RUN = 2'd0, MUL_BUSY = 2'd1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          br, lu, mul_req;
  logic          ex_fwd_ok, wb_fwd_ok;

  assign br        = ex_branch_taken & ex_valid;
  assign mul_req   = id_valid & id_is_mul;
  assign ex_fwd_ok = ex_valid & ex_we & ~ex_is_load;
  assign wb_fwd_ok = wb_valid & wb_we;
  assign lu        = ex_valid & ex_is_load & ex_we & (ex_rd != '0) & id_valid
                   & ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (!br && !lu && mul_req) begin
          state_d = MUL_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MUL_BUSY: begin
        if (br) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    busy        = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    if (!reset) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      if (id_rs1 != '0) begin
        if (ex_fwd_ok && ex_rd == id_rs1)      fwd_a = 2'b01;
        else if (wb_fwd_ok && wb_rd == id_rs1) fwd_a = 2'b10;
      end
      if (id_uses_rs2 && id_rs2 != '0) begin
        if (ex_fwd_ok && ex_rd == id_rs2)      fwd_b = 2'b01;
        else if (wb_fwd_ok && wb_rd == id_rs2) fwd_b = 2'b10;
      end
      busy = (state_q == MUL_BUSY);
      if (br) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if ((state_q == RUN && (lu || mul_req)) ||
                   (state_q == MUL_BUSY && cnt_q != '0)) begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_we && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (br && flush_q != '1)     flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MUL_CYCLES=4); counter checks follow HAZARD_PERF_EN.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_uses_rs2, id_is_mul;
  logic [2:0]  id_rs1, id_rs2, ex_rd, wb_rd;
  logic        ex_valid, ex_we, ex_is_load, ex_branch_taken;
  logic        wb_valid, wb_we;
  logic        pc_we, ifid_we, ifid_flush, idex_bubble, busy;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.RAW(3), .MUL_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .id_is_mul(id_is_mul),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .busy(busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {pc_we, ifid_we, ifid_flush, idex_bubble, busy}
  task automatic ctl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, pc_we, ifid_we, ifid_flush, idex_bubble, busy}, {27'd0, exp});
  endtask

  task automatic perf(input string tag, input int exp_stall, input int exp_flush);
`ifdef HAZARD_PERF_EN
    chk({tag, "_stall"}, {16'd0, stall_cnt}, exp_stall);
    chk({tag, "_flush"}, {16'd0, flush_cnt}, exp_flush);
`else
    chk({tag, "_stall"}, {16'd0, stall_cnt}, 32'd0);
    chk({tag, "_flush"}, {16'd0, flush_cnt}, 32'd0);
`endif
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0; id_is_mul = 0;
    ex_valid = 0; ex_rd = 0; ex_we = 0; ex_is_load = 0; ex_branch_taken = 0;
    wb_valid = 0; wb_rd = 0; wb_we = 0;
  endtask

  task automatic rand_inputs();
    id_valid = 1'($urandom); id_rs1 = 3'($urandom); id_rs2 = 3'($urandom);
    id_uses_rs2 = 1'($urandom); id_is_mul = 1'($urandom);
    ex_valid = 1'($urandom); ex_rd = 3'($urandom); ex_we = 1'($urandom);
    ex_is_load = 1'($urandom); ex_branch_taken = 1'($urandom);
    wb_valid = 1'($urandom); wb_rd = 3'($urandom); wb_we = 1'($urandom);
  endtask

  initial begin
    idle();
    reset = 1'b0;

    // T1: reset hold with random inputs, then async reset in MUL_BUSY
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); rand_inputs(); #1;
      ctl("rst_hold_ctl", 5'b00110);
      chk("rst_hold_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
      perf("rst_hold", 0, 0);
    end
    @(negedge clk); idle(); reset = 1'b1; #1;
    ctl("rst_release", 5'b11000);
    @(negedge clk); id_valid = 1; id_is_mul = 1; #1;
    ctl("rst_mul_entry", 5'b00010);
    @(negedge clk); #1;
    ctl("rst_mul_busy", 5'b00011);
    reset = 1'b0; #1;
    ctl("rst_async", 5'b00110);
    perf("rst_async", 0, 0);
    @(negedge clk); idle(); reset = 1'b1; #1;
    ctl("rst_back_run", 5'b11000);

    // T2: forwarding
    @(negedge clk);
    id_valid = 1; id_rs1 = 3; ex_valid = 1; ex_rd = 3; ex_we = 1;
    wb_valid = 1; wb_rd = 3; wb_we = 1; #1;
    chk("fwd_ex", {30'd0, fwd_a}, 32'd1);
    chk("fwd_b_unused", {30'd0, fwd_b}, 32'd0);
    ctl("fwd_ctl", 5'b11000);
    @(negedge clk); ex_we = 0; #1;
    chk("fwd_wb", {30'd0, fwd_a}, 32'd2);
    @(negedge clk); ex_we = 1; id_rs1 = 0; ex_rd = 0; wb_rd = 0; #1;
    chk("fwd_r0", {30'd0, fwd_a}, 32'd0);
    @(negedge clk); id_uses_rs2 = 1; id_rs2 = 6; ex_rd = 6; wb_rd = 6; #1;
    chk("fwd_b_ex", {30'd0, fwd_b}, 32'd1);

    // T3: load-use on rs2, then WB forward
    @(negedge clk); idle();
    id_valid = 1; id_rs1 = 1; id_rs2 = 5; id_uses_rs2 = 1;
    ex_valid = 1; ex_is_load = 1; ex_we = 1; ex_rd = 5; #1;
    ctl("lu_stall", 5'b00010);
    chk("lu_fwd_b", {30'd0, fwd_b}, 32'd0);
    @(negedge clk); ex_valid = 0; ex_is_load = 0; ex_we = 0; ex_rd = 0;
    wb_valid = 1; wb_rd = 5; wb_we = 1; #1;
    ctl("lu_after", 5'b11000);
    chk("lu_fwd_wb", {30'd0, fwd_b}, 32'd2);

    // clear counters so T4 counts from zero
    @(negedge clk); idle(); reset = 1'b0; #1; reset = 1'b1; #1;
    perf("pre_mul", 0, 0);

    // T4: MUL stalls 4 cycles, releases on cycle 5
    @(negedge clk); id_valid = 1; id_is_mul = 1; #1;
    ctl("mul_c1", 5'b00010);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk); #1;
      ctl("mul_busy", 5'b00011);
    end
    @(negedge clk); #1;
    ctl("mul_release", 5'b11001);
    @(negedge clk); idle(); #1;
    ctl("mul_done", 5'b11000);
    perf("mul", 4, 0);

    // T5: branch beats MUL in the same cycle
    @(negedge clk); id_valid = 1; id_is_mul = 1; ex_valid = 1; ex_branch_taken = 1; #1;
    ctl("br_vs_mul", 5'b11110);
    @(negedge clk); idle(); #1;
    ctl("br_no_busy", 5'b11000);
    perf("br_mul", 4, 1);

    // T6: branch beats load-use; unqualified branch ignored
    @(negedge clk);
    id_valid = 1; id_rs1 = 5; ex_valid = 1; ex_is_load = 1; ex_we = 1; ex_rd = 5;
    ex_branch_taken = 1; #1;
    ctl("br_vs_lu", 5'b11110);
    @(negedge clk); idle(); id_valid = 1; ex_branch_taken = 1; #1;
    ctl("br_invalid", 5'b11000);
    perf("br_lu", 4, 2);

    // branch arriving during MUL_BUSY aborts the stall
    @(negedge clk); idle(); id_valid = 1; id_is_mul = 1; #1;
    ctl("mul2_entry", 5'b00010);
    @(negedge clk); ex_valid = 1; ex_branch_taken = 1; #1;
    ctl("br_in_busy", 5'b11111);
    @(negedge clk); idle(); #1;
    ctl("br_busy_exit", 5'b11000);
    perf("final", 5, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
